// File: rtl/image_row_feeder.sv
// Pixel-serial to row-parallel feeder: packs W pixels into a row word, paces rows with a gap,
// optionally holds after each frame. Optional sticky overrun flag under `FEEDER_OVERRUN_EN.
module image_row_feeder #(
   parameter int W          = 24,
   parameter int H          = 24,
   parameter int DATA_BITS  = 8,
   parameter int ROW_GAP    = 32,
   parameter int HOLD_FRAME = 1
) (
   input  logic                                  clk,
   input  logic                                  resetn,
   input  logic [DATA_BITS-1:0]                  pix_i,
   input  logic                                  pix_valid_i,
   output logic                                  pix_ready_o,
   input  logic                                  frame_release_i,
   output logic [W*DATA_BITS-1:0]                row_o,
   output logic                                  row_valid_o,
   output logic [((H > 1) ? $clog2(H) : 1)-1:0]  row_idx_o,
   output logic                                  frame_done_o,
   output logic                                  busy_o
`ifdef FEEDER_OVERRUN_EN
   ,output logic                                 overrun_o
`endif
);

   localparam int COL_W = (W > 1) ? $clog2(W) : 1;
   localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
   localparam int GAP_W = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

   typedef enum logic [1:0] {FILL, EMIT, GAP, HOLD} state_t;

   state_t                 state, state_nxt;
   logic [COL_W-1:0]       col;
   logic [ROW_W-1:0]       row;
   logic [GAP_W-1:0]       gap;
   logic [W*DATA_BITS-1:0] shadow;
   logic [W*DATA_BITS-1:0] row_nxt;
   logic                   xfer;
   logic                   last_col;
   logic                   last_row;

   assign xfer     = pix_valid_i && (state == FILL);
   assign last_col = (col == COL_W'(W - 1));
   assign last_row = (row == ROW_W'(H - 1));

   // Completed row = shadow with the final pixel merged in, so row_o never sees a partial row.
   always_comb begin
      row_nxt = shadow;
      row_nxt[col*DATA_BITS +: DATA_BITS] = pix_i;
   end

   always_comb begin
      state_nxt    = state;
      pix_ready_o  = 1'b0;
      row_valid_o  = 1'b0;
      frame_done_o = 1'b0;
      case (state)
         FILL: begin
            pix_ready_o = 1'b1;
            if (pix_valid_i && last_col) state_nxt = EMIT;
         end
         EMIT: begin
            row_valid_o  = 1'b1;
            frame_done_o = last_row;
            if (last_row && (HOLD_FRAME != 0)) state_nxt = HOLD;
            else if (ROW_GAP > 0)              state_nxt = GAP;
            else                               state_nxt = FILL;
         end
         GAP: begin
            if (gap == '0) state_nxt = FILL;
         end
         HOLD: begin
            if (frame_release_i) state_nxt = (ROW_GAP > 0) ? GAP : FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   // Shadow is pure data: every slot is rewritten before it is ever copied out.
   always_ff @(posedge clk) begin
      if (xfer) shadow[col*DATA_BITS +: DATA_BITS] <= pix_i;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= FILL;
         col       <= '0;
         row       <= '0;
         gap       <= '0;
         row_o     <= '0;
         row_idx_o <= '0;
         busy_o    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            FILL: begin
               if (xfer) begin
                  busy_o <= 1'b1;
                  if (last_col) begin
                     row_o     <= row_nxt;
                     row_idx_o <= row;
                     col       <= '0;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            EMIT: begin
               row <= last_row ? '0 : row + 1'b1;
               if (state_nxt == GAP) gap <= GAP_LOAD;
               if (last_row && (HOLD_FRAME == 0)) busy_o <= 1'b0;
            end
            GAP: begin
               if (gap != '0) gap <= gap - 1'b1;
            end
            HOLD: begin
               if (frame_release_i) begin
                  busy_o <= 1'b0;
                  if (state_nxt == GAP) gap <= GAP_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FEEDER_OVERRUN_EN
   // Sticky: a source without back-pressure offered a pixel we could not take.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                          overrun_o <= 1'b0;
      else if (pix_valid_i && !pix_ready_o) overrun_o <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_image_row_feeder.sv
// Directed bench for image_row_feeder (W=H=24, 8-bit pixels, ROW_GAP=32, HOLD_FRAME=1).
// Overrun checks are compiled in only when FEEDER_OVERRUN_EN is defined.
module tb_image_row_feeder;

   localparam int W = 24;
   localparam int H = 24;

   logic         clk = 1'b0;
   logic         resetn;
   logic [7:0]   pix;
   logic         pix_valid;
   logic         pix_ready;
   logic         frame_release;
   logic [191:0] row;
   logic         row_valid;
   logic [4:0]   row_idx;
   logic         frame_done;
   logic         busy;
`ifdef FEEDER_OVERRUN_EN
   logic         overrun;
`endif

   image_row_feeder #(.W(W), .H(H), .DATA_BITS(8), .ROW_GAP(32), .HOLD_FRAME(1)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .pix_i           (pix),
      .pix_valid_i     (pix_valid),
      .pix_ready_o     (pix_ready),
      .frame_release_i (frame_release),
      .row_o           (row),
      .row_valid_o     (row_valid),
      .row_idx_o       (row_idx),
      .frame_done_o    (frame_done),
      .busy_o          (busy)
`ifdef FEEDER_OVERRUN_EN
      ,.overrun_o      (overrun)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] base;
      logic [4:0] idx;
      logic       fdone;
      int         wait_c;
      int         space;
      int         rel_at;
   } vec_t;

   vec_t tbl[24];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   waited;
   bit   stuck = 1'b0;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [191:0] exp_row(input logic [7:0] base);
      logic [191:0] r;
      for (int c = 0; c < W; c++) r[c*8 +: 8] = base + 8'(c);
      return r;
   endfunction

   // Present one pixel with valid held, wait (bounded) for ready, then take the transfer edge.
   task automatic send_pix(input logic [7:0] d);
      pix       = d;
      pix_valid = 1'b1;
      while (!pix_ready && !stuck) begin
         tick();
         waited++;
         if (waited > 500) begin
            stuck = 1'b1;
            check("ready_timeout", 192'd0, 192'd1);
         end
      end
      tick();
   endtask

   task automatic run_row(input string tag, input logic [7:0] base, input logic [4:0] idx,
                          input logic fdone, input int wait_c, input int rel_at);
      waited = 0;
      for (int c = 0; c < W; c++) begin
         if (c == rel_at) frame_release = 1'b1;
         send_pix(base + 8'(c));
         frame_release = 1'b0;
      end
      check({tag, "_valid"}, 192'(row_valid), 192'd1);
      check({tag, "_data"},  row,             exp_row(base));
      check({tag, "_idx"},   192'(row_idx),   192'(idx));
      check({tag, "_fdone"}, 192'(frame_done), 192'(fdone));
      check({tag, "_busy"},  192'(busy),      192'd1);
      check({tag, "_wait"},  192'(waited),    192'(wait_c));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_row_valid"},  192'(row_valid),  192'd0);
      check({tag, "_ready"},      192'(pix_ready),  192'd1);
      check({tag, "_busy"},       192'(busy),       192'd0);
      check({tag, "_row"},        row,              192'd0);
      check({tag, "_idx"},        192'(row_idx),    192'd0);
      check({tag, "_frame_done"}, 192'(frame_done), 192'd0);
`ifdef FEEDER_OVERRUN_EN
      check({tag, "_overrun"},    192'(overrun),    192'd0);
`endif
   endtask

   initial begin
      int last_pulse;
      int rdy_hi;

      for (int i = 0; i < 24; i++) begin
         tbl[i].base   = 8'(i * 24);
         tbl[i].idx    = 5'(i);
         tbl[i].fdone  = (i == 23);
         tbl[i].wait_c = (i == 0) ? 0 : 33;
         tbl[i].space  = 57;
         tbl[i].rel_at = (i == 5) ? 10 : -1;
      end

      resetn = 1'b0; pix = 8'h00; pix_valid = 1'b0; frame_release = 1'b0;
      repeat (3) tick();
      check_idle("reset");
      resetn = 1'b1;
      tick();

      // Full frame with valid held throughout; release pulse mid-row 5 must be ignored.
      last_pulse = 0;
      for (int i = 0; i < 24; i++) begin
         run_row($sformatf("f0r%0d", i), tbl[i].base, tbl[i].idx, tbl[i].fdone,
                 tbl[i].wait_c, tbl[i].rel_at);
         if (i > 0) check($sformatf("f0r%0d_space", i), 192'(cyc - last_pulse), 192'(tbl[i].space));
         last_pulse = cyc;
`ifdef FEEDER_OVERRUN_EN
         if (i == 0) check("overrun_before_gap", 192'(overrun), 192'd0);
`endif
      end
      pix_valid = 1'b0;
`ifdef FEEDER_OVERRUN_EN
      check("overrun_after_gap", 192'(overrun), 192'd1);
`endif

      tick();
      check("pulse_one_cycle", 192'(row_valid), 192'd0);
      check("fdone_one_cycle", 192'(frame_done), 192'd0);

      rdy_hi = 0;
      for (int k = 0; k < 100; k++) begin
         if (pix_ready) rdy_hi++;
         tick();
      end
      check("hold_ready_low", 192'(rdy_hi), 192'd0);
      check("hold_busy", 192'(busy), 192'd1);
`ifdef FEEDER_OVERRUN_EN
      check("overrun_sticky", 192'(overrun), 192'd1);
`endif

      frame_release = 1'b1;
      tick();
      frame_release = 1'b0;
      check("release_busy_clear", 192'(busy), 192'd0);
      check("release_ready_low", 192'(pix_ready), 192'd0);
      waited = 0;
      while (!pix_ready && waited < 200) begin
         tick();
         waited++;
      end
      check("release_gap_len", 192'(waited), 192'd32);

      run_row("f1r0", 8'h40, 5'd0, 1'b0, 0, -1);
      run_row("f1r1", 8'h58, 5'd1, 1'b0, 33, -1);
      run_row("f1r2", 8'h70, 5'd2, 1'b0, 33, -1);

      // Ten pixels into row 3, then an asynchronous reset between clock edges.
      waited = 0;
      for (int c = 0; c < 10; c++) send_pix(8'h90 + 8'(c));
      check("partial_ready_after_gap", 192'(waited), 192'd33);
      resetn = 1'b0;
      #1;
      check_idle("async_rst");
      pix_valid = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
      run_row("post_rst", 8'hA0, 5'd0, 1'b0, 0, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/image_row_feeder.md
Name: image_row_feeder

Overview:
- Upstream input stage for the CNN pipeline: accepts a pixel-serial byte stream (valid/ready) and packs W pixels into one row word.
- Presents each completed row as a one-cycle row_valid_o pulse with a held row_o bus, sized to drive the first line_3_buffer input_data / valid_i pair directly.
- Enforces a minimum inter-row gap so the line buffer and conv stage can drain.
- Optionally holds after each full frame until the classifier releases it.

Parameters:
- W, 24, pixels per row
- H, 24, rows per frame
- DATA_BITS, 8, bits per pixel
- ROW_GAP, 32, minimum idle cycles after each row pulse before the next pixel is accepted (0 allowed)
- HOLD_FRAME, 1, 1 = wait for frame_release_i after the last row; 0 = start the next frame immediately

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- pix_i  in  DATA_BITS  incoming pixel
- pix_valid_i  in  1  pix_i valid
- pix_ready_o  out  1  feeder can accept; a transfer occurs when pix_valid_i & pix_ready_o
- frame_release_i  in  1  release pulse from downstream (dense valid); used only in HOLD
- row_o  out  W*DATA_BITS  packed row; column c at row_o[c*DATA_BITS +: DATA_BITS]
- row_valid_o  out  1  one-cycle pulse, row_o valid
- row_idx_o  out  clog2(H)  index of the row currently on row_o (0..H-1)
- frame_done_o  out  1  one-cycle pulse coincident with row_valid_o of row H-1
- busy_o  out  1  high from the first accepted pixel of a frame until the frame leaves HOLD (or until the last EMIT when HOLD_FRAME=0)

Behaviour:
- Reset (async assert, sync deassert externally assumed by the codebase flow): state=FILL, col=0, row=0, gap=0, row_o=0, row_valid_o=0, row_idx_o=0, frame_done_o=0, busy_o=0, pix_ready_o=1 (combinational from state).
- States:
  - FILL: pix_ready_o=1. On each transfer, write pix_i into shadow slot col and increment col. On the transfer with col==W-1: copy shadow+pix_i into row_o, set row_idx_o=row, col<=0, go to EMIT.
  - EMIT (1 cycle): row_valid_o=1, frame_done_o=(row_idx_o==H-1), pix_ready_o=0. Increment row, wrapping H-1 -> 0. Next state:
    - last row and HOLD_FRAME=1 -> HOLD
    - else ROW_GAP>0 -> GAP (gap<=ROW_GAP-1)
    - else FILL.
  - GAP: pix_ready_o=0. Decrement gap; when gap==0, go to FILL. Exactly ROW_GAP cycles are spent in GAP.
  - HOLD: pix_ready_o=0. On frame_release_i, go to GAP (ROW_GAP>0) or FILL, and clear busy_o.
- Latency: last pixel of a row accepted at edge t -> row_valid_o high during cycle t+1. row_o and row_idx_o stay stable until the next EMIT.
- Row pulse spacing: at least W+1+ROW_GAP cycles between pulses.
- frame_release_i is ignored outside HOLD; no memory of early pulses.
- pix_valid_i while pix_ready_o=0: no transfer, and the pixel is not lost from the source's perspective.
- Shadow register and row_o are separate, so row_o never shows a partially filled row.
- Reset mid-row discards the partial row; the next accepted pixel is column 0 of row 0.
- Counter widths: col clog2(W), row clog2(H), gap clog2(ROW_GAP+1). No arithmetic on pixel data.

Optional Feature:
- Macro FEEDER_OVERRUN_EN.
- Defined: add output overrun_o (1 bit, reset 0). It is sticky and set in any cycle with pix_valid_i=1 and pix_ready_o=0; only reset clears it. Intended for sources without back-pressure (UART).
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then stream pixels 0x00..0x17 back-to-back with valid held -> single row_valid_o one cycle after the 24th transfer; row_o[7:0]=0x00, row_o[191:184]=0x17; row_idx_o=0.
- Continuous valid over 2 rows with ROW_GAP=32 -> pix_ready_o low for exactly 33 cycles (EMIT+GAP); row pulses 57 cycles apart; second row_idx_o=1.
- Full 24x24 frame with HOLD_FRAME=1 -> frame_done_o with the 24th pulse; pix_ready_o stays 0 for 100 cycles; after a frame_release_i pulse, ready returns after 32 gap cycles; next row_idx_o=0.
- frame_release_i pulsed during FILL of row 5 -> no effect; HOLD is still entered after row 23.
- Assert resetn=0 asynchronously after 10 pixels of row 3 -> all outputs 0 immediately; next 24 pixels form row 0.
- With FEEDER_OVERRUN_EN, drive pix_valid_i=1 during GAP -> overrun_o=1 the next cycle and stays 1 until reset; without the macro, the build has no overrun_o port.
